// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM widths and the line-fetch FSM state type
package vram_pkg;
  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ABORT} fetch_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO with registered head word and synchronous flush
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop, head_from_din;
  assign do_pop = pop && count != '0;
  // A push into an empty (or just-emptied) FIFO becomes the head directly
  assign head_from_din = push && (count == '0 || (count == CW'(1) && do_pop));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
      dout  <= head_from_din ? din : do_pop ? mem[rd_ptr + 1'b1] : dout;
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/vram_line_fetch.sv
// vram_line_fetch: burst reader of consecutive VRAM words into a valid/ready stream
module vram_line_fetch
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [VRAM_ADDR_W-1:0] base_addr,
  input  logic [7:0]             word_count,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic                   vram_strobe,
  input  logic                   vram_ack,
  input  logic [VRAM_DATA_W-1:0] vram_rddata,
  output logic [VRAM_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e state, state_next;
  logic [VRAM_ADDR_W-1:0] addr_next;
  logic [8:0] remaining, remaining_next;
  logic [CW-1:0] count, count_next;
  logic strobe_q, go, push, pop, flush, last_pop;
  assign go = state == IDLE && start;
  // Acks are only honoured when a request was actually on the bus last cycle
  assign push = vram_ack && strobe_q && state == FETCH && !abort;
  assign pop = out_valid && out_ready;
  assign flush = abort && (state == FETCH || state == DRAIN);
  assign last_pop = state == DRAIN && pop && count == CW'(1) && !abort;
  assign count_next = flush ? '0 : count + CW'(push) - CW'(pop);
  assign remaining_next = go ? {word_count == 8'd0, word_count} : push ? remaining - 9'd1 : remaining;
  assign addr_next = go ? base_addr : push ? vram_addr + 1'b1 : vram_addr;
  assign out_valid = count != '0;
  assign busy = state != IDLE;
  always_comb
    state_next = go ? FETCH :
                 flush ? ABORT :
                 (state == FETCH && push && remaining == 9'd1) ? DRAIN :
                 (last_pop || state == ABORT) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vram_addr   <= '0;
      remaining   <= '0;
      vram_strobe <= 1'b0;
      strobe_q    <= 1'b0;
      done        <= 1'b0;
    end else begin
      vram_addr   <= addr_next;
      remaining   <= remaining_next;
      vram_strobe <= state_next == FETCH && remaining_next != 9'd0 && count_next < CW'(FIFO_DEPTH);
      strobe_q    <= vram_strobe;
      done        <= last_pop;
    end
  sync_fifo #(.WIDTH(VRAM_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (vram_rddata),
    .dout  (out_data),
    .count (count)
  );
endmodule

// File: tb/tb_vram_line_fetch.sv
// tb_vram_line_fetch: slot-arbiter model with word[a]=a RAM and scoreboarded output stream
module tb_vram_line_fetch;
  logic clk = 0, rst_n = 1, start = 0, abort = 0, vram_ack = 0, out_ready = 0;
  logic [14:0] base_addr = 0, vram_addr, pend_addr = 0;
  logic [7:0] word_count = 0;
  logic [31:0] vram_rddata = 0, out_data;
  logic busy, done, vram_strobe, out_valid;
  logic [1:0] slot = 0;
  logic pend = 0, grant_now = 0;
  int tests = 0, fails = 0, done_cnt = 0, grants = 0, exp_done = 0;
  logic [31:0] exp_data[$];
  logic [14:0] exp_addr[$];

  always #5 clk = ~clk;

  vram_line_fetch #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_count(word_count),
    .abort(abort), .busy(busy), .done(done), .vram_addr(vram_addr), .vram_strobe(vram_strobe),
    .vram_ack(vram_ack), .vram_rddata(vram_rddata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arbiter: this port owns slot 0 of 4; ack with RAM data the cycle after the grant
  always @(posedge clk) begin
    #1;
    vram_ack = pend;
    vram_rddata = {17'b0, pend_addr};
    grant_now = slot == 2'd0 && vram_strobe === 1'b1;
    if (grant_now) begin
      grants++;
      if (exp_addr.size() == 0) begin
        tests++; fails++;
        $display("FAIL strobe_addr: unexpected request at %h", vram_addr);
      end else check("strobe_addr", {17'b0, vram_addr}, {17'b0, exp_addr.pop_front()});
    end
    pend = grant_now;
    pend_addr = vram_addr;
    slot = slot + 2'd1;
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_data.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_data: unexpected word %h", out_data);
      end else check("out_data", out_data, exp_data.pop_front());
    end
    if (done) begin
      done_cnt++;
      check("busy_at_done", {31'b0, busy}, 0);
    end
  end

  task automatic run(input logic [14:0] b, input logic [7:0] n);
    int len = n == 8'd0 ? 256 : int'(n);
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(b + 15'(i));
      exp_data.push_back({17'b0, 15'(b + 15'(i))});
    end
    @(posedge clk); #2;
    base_addr = b; word_count = n; start = 1;
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic finish_run(input string name, input int budget);
    int c = 0;
    while (busy && c < budget) begin @(posedge clk); #2; c++; end
    check({name, "_idle"}, {31'b0, busy}, 0);
    repeat (2) @(posedge clk);
    #2;
    exp_done++;
    check({name, "_done_count"}, done_cnt, exp_done);
    check({name, "_all_words"}, exp_data.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, {31'b0, busy}, 0);
    check({name, "_done"}, {31'b0, done}, 0);
    check({name, "_strobe"}, {31'b0, vram_strobe}, 0);
    check({name, "_addr"}, {17'b0, vram_addr}, 0);
    check({name, "_valid"}, {31'b0, out_valid}, 0);
    check({name, "_data"}, out_data, 0);
  endtask

  task automatic wait_grant(input string name, input int target);
    int c = 0;
    while (!(grant_now && grants == target) && c < 200) begin @(posedge clk); #2; c++; end
    check({name, "_grant_seen"}, {31'b0, grant_now}, 1);
  endtask

  initial begin
    int lat, g0, d0;
    #1 rst_n = 0;
    #2 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1;
    repeat (2) @(posedge clk);
    #2;

    // Basic 4-word run with latency bound
    out_ready = 1;
    run(15'h0010, 8'd4);
    lat = 1;
    while (!out_valid && lat < 10) begin @(posedge clk); #2; lat++; end
    check("first_valid_latency_ok", {31'b0, lat >= 3 && lat <= 6}, 1);
    finish_run("basic", 100);

    // Address wrap
    run(15'h7FFE, 8'd3);
    finish_run("wrap", 100);

    // word_count 0 means 256
    run(15'h1000, 8'd0);
    finish_run("full256", 2000);

    // Back-pressure: FIFO fills to 8 and strobe drops
    out_ready = 0;
    g0 = grants;
    run(15'h0100, 8'd20);
    repeat (60) @(posedge clk);
    #2;
    check("bp_grants", grants - g0, 8);
    check("bp_strobe_low", {31'b0, vram_strobe}, 0);
    check("bp_valid", {31'b0, out_valid}, 1);
    out_ready = 1;
    finish_run("bp", 400);

    // Abort in the cycle the arbiter samples the strobe
    out_ready = 0;
    g0 = grants;
    d0 = done_cnt;
    run(15'h0200, 8'd10);
    wait_grant("abort", g0 + 3);
    abort = 1;
    exp_data.delete();
    exp_addr.delete();
    @(posedge clk); #2;
    abort = 0;
    check("abort_flush_valid", {31'b0, out_valid}, 0);
    check("abort_ack_present", {31'b0, vram_ack}, 1);
    @(posedge clk); #2;
    check("abort_straggler_valid", {31'b0, out_valid}, 0);
    check("abort_idle", {31'b0, busy}, 0);
    check("abort_strobe", {31'b0, vram_strobe}, 0);
    repeat (5) @(posedge clk);
    #2;
    check("abort_no_done", done_cnt, d0);
    check("abort_stays_empty", {31'b0, out_valid}, 0);
    exp_done = done_cnt;
    out_ready = 1;
    run(15'h0300, 8'd5);
    finish_run("after_abort", 100);

    // Asynchronous reset mid-FETCH with a straggler ack afterwards
    g0 = grants;
    run(15'h0400, 8'd10);
    wait_grant("rst", g0 + 2);
    rst_n = 0;
    #1 check_reset_outputs("midrst");
    exp_data.delete();
    exp_addr.delete();
    #3 rst_n = 1;
    @(posedge clk); #2;
    check("rst_straggler_ack", {31'b0, vram_ack}, 1);
    @(posedge clk); #2;
    check("rst_straggler_valid", {31'b0, out_valid}, 0);
    check("rst_straggler_busy", {31'b0, busy}, 0);
    repeat (3) @(posedge clk);
    #2;
    check("rst_still_empty", {31'b0, out_valid}, 0);
    exp_done = done_cnt;
    run(15'h0020, 8'd2);
    finish_run("after_rst", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vram_line_fetch.md
# vram_line_fetch

Burst read engine that sits directly upstream of the VRAM time-slotted arbiter on one of its 32-bit read-only ports (if1..if3). On a start command it fetches a run of consecutive 32-bit VRAM words, hiding the arbiter's 1-in-4 slot latency behind a small FIFO. It presents the words to a layer renderer through a valid/ready stream. Supports abort for mid-line reconfiguration.

## Interface
- FIFO_DEPTH, 8: output FIFO entries; power of two, 2..16.
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- base_addr  in  15  first VRAM word address, sampled with start.
- word_count  in  8  words to fetch, sampled with start; 0 means 256.
- abort  in  1  cancel the current run; ignored while idle.
- busy  out  1  high from the cycle after an accepted start until done or abort completes.
- done  out  1  one-cycle pulse after the last word is popped.
- vram_addr  out  15  to arbiter ifN_addr; registered.
- vram_strobe  out  1  to arbiter ifN_strobe; registered.
- vram_ack  in  1  from arbiter ifN_ack; vram_rddata is valid in the same cycle.
- vram_rddata  in  32  from arbiter ifN_rddata.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts; a pop occurs when out_valid && out_ready.

## Operation
- States: IDLE, FETCH, DRAIN, ABORT.
- IDLE → FETCH on start:
  - Load addr=base_addr.
  - Load remaining = word_count (9-bit; 0 loads 256).
- FETCH:
  - vram_strobe=1, with vram_addr held constant, whenever remaining>0 and fifo_count_next < FIFO_DEPTH.
  - At most one request is outstanding.
  - On vram_ack: push vram_rddata into the FIFO, addr<=addr+1 (wraps 0x7FFF→0x0000), and remaining<=remaining-1.
  - Strobe re-evaluates the same edge, so the next address is presented from the cycle after ack.
- FETCH → DRAIN when the final ack is received (remaining goes to 0). vram_strobe=0 from then on.
- DRAIN → IDLE when the FIFO becomes empty via a pop. done=1 for exactly one cycle, in the cycle after that pop. busy=0 from the same cycle.
- abort in FETCH or DRAIN:
  - Next state is ABORT; vram_strobe<=0.
  - Flush the FIFO (count=0, out_valid=0).
  - Hold ABORT one cycle. Discard any vram_ack arriving in that cycle, since the strobe may have been sampled in the arbiter slot of the abort cycle.
  - ABORT → IDLE, with no done pulse.
- Simultaneous events:
  - start and abort together in IDLE: start wins.
  - A push and a pop in the same cycle leave the count unchanged.
  - An ack that fills the FIFO drops the strobe next cycle.
- An ack received while vram_strobe was 0 in the previous cycle is a protocol error. It is ignored; there is no push.
- Reset values: state=IDLE, busy=0, done=0, vram_strobe=0, vram_addr=0, out_valid=0, out_data=0, FIFO count=0.

## Timing
- Start accepted at edge E; vram_strobe=1 in cycle E+1.
- The arbiter grants within 0–3 cycles. ack arrives one cycle after the grant slot. out_valid rises the cycle after ack.
- Start-to-first-out_valid: 3 cycles minimum, 6 cycles maximum.
- Sustained throughput: 1 word per 4 cycles, matching slot bandwidth.
- FIFO output is registered. A pop at edge P shows the next head word in cycle P+1.
- Reset mid-run returns everything to reset values asynchronously. The arbiter may still return one ack after reset release; it is dropped because state=IDLE.

## Structure
- Shared package vram_pkg:
  - VRAM_ADDR_W=15, VRAM_DATA_W=32.
  - Typedef for the fetch FSM state enum.
  - The arbiter and the CPU-side port use the same constants.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/count/flush, asynchronous active-low reset). The FSM, address counter and remaining counter stay in vram_line_fetch.

## Test plan
- Arbiter model plus a RAM preloaded with word[a]=a. start with base=0x0010, count=4, out_ready=1:
  - out_data 0x10,0x11,0x12,0x13 in order.
  - done pulses once; busy falls in the same cycle as done.
- base=0x7FFE, count=3: addresses 0x7FFE, 0x7FFF, 0x0000 are strobed.
- count=0: exactly 256 words are delivered and then done.
- out_ready=0, count=20, FIFO_DEPTH=8:
  - Strobe stops after 8 pushes; FIFO count never exceeds 8.
  - On releasing out_ready, all 20 words arrive intact.
- Abort in the cycle the strobe is sampled in the arbiter slot:
  - The following ack is discarded; out_valid=0 the next cycle; no done.
  - A new start then delivers correct data.
- rst_n asserted mid-FETCH: all outputs return to reset values immediately. A straggler ack after release produces no out_valid.
